// File: rtl/mips_bridge_pkg.sv
// rtl/mips_bridge_pkg.sv - shared timer state encoding, register map and decode helper
package mips_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_PRESET = 2'd1;
    localparam logic [1:0] IDX_COUNT  = 2'd2;
    localparam logic [1:0] IDX_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    localparam logic [31:0] TC0_BASE_DEFAULT = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE_DEFAULT = 32'h0000_7F10;

    // A block occupies 16 bytes; the fourth word slot is unmapped.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
        return (addr[31:4] == base[31:4]) && (addr[3:2] != IDX_RSVD);
    endfunction

endpackage

// File: rtl/mips_timer.sv
// rtl/mips_timer.sv - one down-counting timer with CTRL/PRESET/COUNT registers and IRQ
module mips_timer
    import mips_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  widx,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl,
    output logic [31:0] preset,
    output logic [31:0] count,
    output logic        irq
);

    timer_state_e state, next_state;
    logic         en;
    logic [1:0]   mode;
    logic         im;
    logic [31:0]  preset_q;
    logic [31:0]  count_q;
    logic         irq_flag;
    logic         wr_ctrl;
    logic         wr_preset;

    assign wr_ctrl   = we && (widx == IDX_CTRL);
    assign wr_preset = we && (widx == IDX_PRESET);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (en) next_state = ST_LOAD;
            ST_LOAD: next_state = ST_CNT;
            ST_CNT: begin
                if (!en)
                    next_state = ST_IDLE;
                else if (count_q == 32'd0)
                    next_state = ST_INT;
            end
            ST_INT:  next_state = (mode == MODE_PERIODIC) ? ST_LOAD : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            en       <= 1'b0;
            mode     <= 2'd0;
            im       <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state <= next_state;

            // The CPU's CTRL write takes precedence over the one-shot disabling itself.
            if (wr_ctrl) begin
                en   <= wdata[CTRL_EN];
                mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                im   <= wdata[CTRL_IM];
            end else if (state == ST_INT && mode != MODE_PERIODIC) begin
                en <= 1'b0;
            end

            if (wr_preset)
                preset_q <= wdata;

            if (state == ST_LOAD)
                count_q <= preset_q;
            else if (state == ST_CNT && en && count_q != 32'd0)
                count_q <= count_q - 32'd1;

            // Periodic mode pulses for the single cycle after INT; one-shot latches.
            if (state == ST_INT)
                irq_flag <= 1'b1;
            else if (mode == MODE_PERIODIC || wr_ctrl || wr_preset)
                irq_flag <= 1'b0;
        end
    end

    assign ctrl   = {28'd0, im, mode, en};
    assign preset = preset_q;
    assign count  = count_q;
    assign irq    = im & irq_flag;

endmodule

// File: rtl/mips_bridge.sv
// rtl/mips_bridge.sv - CPU-to-timer bridge; timer 1 present only with MIPS_BRIDGE_TIMER1_EN
module mips_bridge
    import mips_bridge_pkg::*;
#(
    parameter logic [31:0] TC0_BASE = TC0_BASE_DEFAULT,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] CPUAddress,
    input  logic        MemWriteM,
    input  logic [31:0] CPUWriteData,
    output logic [31:0] CPUReadData,
    output logic        DevHit,
    output logic [5:0]  HWInt
);

    logic [1:0]  idx;
    logic        tc0_hit, tc1_hit;
    logic [31:0] tc0_ctrl, tc0_preset, tc0_count;
    logic [31:0] tc1_ctrl, tc1_preset, tc1_count;
    logic        tc0_irq, tc1_irq;

    assign idx     = CPUAddress[3:2];
    assign tc0_hit = addr_hit(CPUAddress, TC0_BASE);

    mips_timer u_tc0 (
        .clk    (clk),
        .reset  (reset),
        .we     (MemWriteM && tc0_hit),
        .widx   (idx),
        .wdata  (CPUWriteData),
        .ctrl   (tc0_ctrl),
        .preset (tc0_preset),
        .count  (tc0_count),
        .irq    (tc0_irq)
    );

`ifdef MIPS_BRIDGE_TIMER1_EN
    localparam bit TIMER1_PRESENT = 1'b1;

    mips_timer u_tc1 (
        .clk    (clk),
        .reset  (reset),
        .we     (MemWriteM && tc1_hit),
        .widx   (idx),
        .wdata  (CPUWriteData),
        .ctrl   (tc1_ctrl),
        .preset (tc1_preset),
        .count  (tc1_count),
        .irq    (tc1_irq)
    );
`else
    localparam bit TIMER1_PRESENT = 1'b0;

    assign tc1_ctrl   = 32'd0;
    assign tc1_preset = 32'd0;
    assign tc1_count  = 32'd0;
    assign tc1_irq    = 1'b0;
`endif

    assign tc1_hit = TIMER1_PRESENT && addr_hit(CPUAddress, TC1_BASE);

    function automatic logic [31:0] sel_reg(input logic [1:0] i, input logic [31:0] c,
                                            input logic [31:0] p, input logic [31:0] n);
        case (i)
            IDX_CTRL:   return c;
            IDX_PRESET: return p;
            IDX_COUNT:  return n;
            default:    return 32'd0;
        endcase
    endfunction

    always_comb begin
        CPUReadData = 32'd0;
        if (tc0_hit)
            CPUReadData = sel_reg(idx, tc0_ctrl, tc0_preset, tc0_count);
        else if (tc1_hit)
            CPUReadData = sel_reg(idx, tc1_ctrl, tc1_preset, tc1_count);
    end

    assign DevHit = tc0_hit || tc1_hit;
    assign HWInt  = {4'b0000, tc1_irq, tc0_irq};

endmodule

// File: tb/tb_mips_bridge.sv
// tb/tb_mips_bridge.sv - randomized self-checking bench for mips_bridge against a closed-form timer model
module tb_mips_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] CPUAddress = 32'd0;
    logic        MemWriteM = 1'b0;
    logic [31:0] CPUWriteData = 32'd0;
    logic [31:0] CPUReadData;
    logic        DevHit;
    logic [5:0]  HWInt;

    int checks = 0;
    int errors = 0;

    mips_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .CPUAddress   (CPUAddress),
        .MemWriteM    (MemWriteM),
        .CPUWriteData (CPUWriteData),
        .CPUReadData  (CPUReadData),
        .DevHit       (DevHit),
        .HWInt        (HWInt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        CPUAddress = a;
        #1;
        d = CPUReadData;
        h = DevHit;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        CPUAddress   = a;
        CPUWriteData = d;
        MemWriteM    = 1'b1;
        step();
        MemWriteM    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // t = cycles since the edge that enabled the timer (fresh from reset).
    // Counting starts two cycles later; one-shot raises IRQ at P+4, periodic repeats every P+3.
    function automatic void model(input int p, input int mode, input int im, input int t,
                                  output logic [31:0] cnt, output logic [31:0] ctrlv,
                                  output logic irq);
        int phase;
        int en;
        en = 1;
        irq = 1'b0;
        cnt = 32'd0;
        if (t >= 2) begin
            if (mode == 1) begin
                phase = (t - 2) % (p + 3);
                cnt = (phase <= p) ? 32'(p - phase) : 32'd0;
                irq = (phase == p + 2);
            end else begin
                cnt = (p - (t - 2) > 0) ? 32'(p - (t - 2)) : 32'd0;
                irq = (t >= p + 4);
                en = (t >= p + 4) ? 0 : 1;
            end
        end
        irq = irq && (im != 0);
        ctrlv = 32'(im * 8 + mode * 2 + en);
    endfunction

    task automatic run_timer(input logic [31:0] base, input int bitpos, input int p,
                             input int mode, input int im, input bit mid);
        logic [31:0] d, ecnt, ectrl, epre;
        logic        h, eirq;
        int          cycles;
        cycles = (mode == 1) ? 3 * (p + 3) + 4 : p + 10;
        do_reset();
        wr(base + 32'h4, 32'(p));
        wr(base, 32'(im * 8 + mode * 2 + 1));
        for (int t = 1; t <= cycles; t++) begin
            if (mid && t == 4)
                wr(base + 32'h4, 32'h0000_00FF);
            else
                step();
            model(p, mode, im, t, ecnt, ectrl, eirq);
            epre = (mid && t >= 4) ? 32'h0000_00FF : 32'(p);
            rd(base + 32'h8, d, h);
            check($sformatf("count p=%0d m=%0d t=%0d", p, mode, t), d, ecnt);
            rd(base, d, h);
            check($sformatf("ctrl p=%0d m=%0d t=%0d", p, mode, t), d, ectrl);
            rd(base + 32'h4, d, h);
            check($sformatf("preset p=%0d t=%0d", p, t), d, epre);
            check($sformatf("hwint p=%0d m=%0d t=%0d", p, mode, t),
                  32'(HWInt), eirq ? (32'd1 << bitpos) : 32'd0);
        end
        if (mode != 1) begin
            wr(base, 32'(im * 8 + mode * 2));
            check("hwint cleared by ctrl write", 32'(HWInt), 32'd0);
            rd(base, d, h);
            check("ctrl after clear write", d, 32'(im * 8 + mode * 2));
        end
    endtask

    initial begin
        logic [31:0] d, r;
        logic        h;
        int          p, mode, im;
        bit          mid;

        do_reset();
        rd(32'h7F00, d, h); check("reset ctrl", d, 32'd0); check("reset hit ctrl", 32'(h), 32'd1);
        rd(32'h7F04, d, h); check("reset preset", d, 32'd0);
        rd(32'h7F08, d, h); check("reset count", d, 32'd0);
        check("reset hwint", 32'(HWInt), 32'd0);

        run_timer(32'h7F00, 0, 5, 0, 1, 1'b0);
        run_timer(32'h7F00, 0, 0, 0, 1, 1'b0);
        run_timer(32'h7F00, 0, 3, 1, 1, 1'b0);
        run_timer(32'h7F00, 0, 6, 0, 1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            p    = int'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 3));
            im   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            mid  = (mode != 1) && (p >= 3) && ($urandom_range(0, 1) == 1);
            run_timer(32'h7F00, 0, p, mode, im, mid);
        end

        // CPU re-enable coinciding with the one-shot's INT cycle keeps EN set
        do_reset();
        wr(32'h7F04, 32'd0);
        wr(32'h7F00, 32'h9);
        step(); step(); step();
        wr(32'h7F00, 32'h9);
        rd(32'h7F00, d, h);
        check("ctrl write beats en clear", d, 32'h9);

        // Reset mid-count also overrides a simultaneous PRESET write
        do_reset();
        wr(32'h7F04, 32'd6);
        wr(32'h7F00, 32'h9);
        for (int t = 1; t <= 5; t++) step();
        rd(32'h7F08, d, h);
        check("count before reset", d, 32'd3);
        CPUAddress = 32'h7F04; CPUWriteData = 32'h55; MemWriteM = 1'b1; reset = 1'b1;
        step();
        MemWriteM = 1'b0; reset = 1'b0;
        rd(32'h7F08, d, h); check("count after reset", d, 32'd0);
        rd(32'h7F04, d, h); check("preset after reset+write", d, 32'd0);
        rd(32'h7F00, d, h); check("ctrl after reset", d, 32'd0);
        check("hwint after reset", 32'(HWInt), 32'd0);
        step(); step(); step();
        rd(32'h7F08, d, h); check("count stays idle", d, 32'd0);

        // Unmapped addresses
        wr(32'h7F04, 32'h1234);
        rd(32'h7F07, d, h); check("preset low bits ignored", d, 32'h1234);
        r = $urandom;
        CPUAddress = 32'h7F0C; CPUWriteData = r; MemWriteM = 1'b1; #1;
        check("hit 7F0C", 32'(DevHit), 32'd0); check("rdata 7F0C", CPUReadData, 32'd0);
        step();
        CPUAddress = 32'h1000; CPUWriteData = ~r; #1;
        check("hit 1000", 32'(DevHit), 32'd0); check("rdata 1000", CPUReadData, 32'd0);
        step();
        MemWriteM = 1'b0;
        rd(32'h7F04, d, h); check("preset unchanged", d, 32'h1234);
        rd(32'h7F00, d, h); check("ctrl unchanged", d, 32'd0);

`ifdef MIPS_BRIDGE_TIMER1_EN
        run_timer(32'h7F10, 1, 3, 1, 1, 1'b0);
        run_timer(32'h7F10, 1, 2, 0, 1, 1'b0);
`else
        do_reset();
        wr(32'h7F14, 32'd7);
        rd(32'h7F14, d, h);
        check("t1 absent read", d, 32'd0); check("t1 absent hit", 32'(h), 32'd0);
        wr(32'h7F10, 32'hB);
        for (int t = 0; t < 12; t++) begin
            step();
            check("t1 absent hwint", 32'(HWInt), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_bridge.md
MIPS_BRIDGE -- requirements
Module: mips_bridge

Interface
REQ-001 SHALL have parameter TC0_BASE, default 32'h0000_7F00, timer 0 register-block base address.
REQ-002 SHALL have parameter TC1_BASE, default 32'h0000_7F10, timer 1 register-block base address.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port CPUAddress  input  32  CPU M-stage byte address.
REQ-006 SHALL have port MemWriteM  input  1  CPU M-stage store strobe.
REQ-007 SHALL have port CPUWriteData  input  32  store data.
REQ-008 SHALL have port CPUReadData  output  32  device read data, combinational.
REQ-009 SHALL have port DevHit  output  1  CPUAddress selects a valid device register, combinational.
REQ-010 SHALL have port HWInt  output  6  hardware interrupt lines to the CPU.

Function
REQ-011 Decode SHALL use CPUAddress[31:4] == base[31:4]; register index = CPUAddress[3:2]; CPUAddress[1:0] ignored.
REQ-012 Index 0 SHALL be CTRL (bit0 EN, bits2:1 MODE, bit3 IM, bits31:4 read 0); index 1 PRESET (32 bit, R/W); index 2 COUNT (read-only); index 3 SHALL read 0, ignore writes, give DevHit=0.
REQ-013 Register write SHALL occur when MemWriteM=1, decode hit and index is 0 or 1; writes to COUNT SHALL be ignored.
REQ-014 CPUReadData SHALL be the addressed register, or 32'h0 when DevHit=0.
REQ-015 Each timer FSM SHALL have states IDLE, LOAD, CNT, INT.
REQ-016 IDLE: EN=1 -> LOAD next cycle; else stay.
REQ-017 LOAD: COUNT <= PRESET; -> CNT.
REQ-018 CNT: EN=0 -> IDLE with COUNT held; COUNT != 0 -> COUNT-1; COUNT == 0 -> INT.
REQ-019 INT, MODE 0 (and MODE 2/3): EN <= 0, irq_flag <= 1 (latched), -> IDLE.
REQ-020 INT, MODE 1: irq_flag <= 1 for exactly one cycle, -> LOAD (periodic reload).
REQ-021 irq_flag (MODE 0) SHALL clear on any CPU write to that timer's CTRL or PRESET.
REQ-022 Timer IRQ SHALL equal IM & irq_flag; HWInt[0] = timer 0 IRQ, HWInt[1] = timer 1 IRQ, HWInt[5:2] = 0.
REQ-023 A CPU CTRL write in the same cycle as the FSM clearing EN SHALL win.
REQ-024 A PRESET write during CNT SHALL not alter COUNT until the next LOAD.
REQ-025 PRESET = 0 SHALL give INT two cycles after LOAD.

Reset
REQ-026 On reset: CTRL, PRESET, COUNT, irq_flag = 0, FSM = IDLE, so HWInt = 0 next cycle; reset SHALL override any simultaneous write.

Configuration
REQ-027 With macro MIPS_BRIDGE_TIMER1_EN defined, timer 1 SHALL be instantiated; without it, TC1_BASE range SHALL give DevHit=0, read 0, ignore writes, and HWInt[1]=0.

Structure
REQ-028 A shared package SHALL hold FSM state encoding, register index constants, CTRL bit positions and default base addresses.
REQ-029 Timer SHALL be one sub-module, mips_timer, instantiated per timer; mips_bridge holds decode, write-enable and read mux only.

Verification
REQ-030 Reset, then read 0x7F00/0x7F04/0x7F08 -> all 0, HWInt=0.
REQ-031 Write PRESET=5, CTRL=0x9 (EN, MODE0, IM) to 0x7F00 -> COUNT 5..0, HWInt[0]=1 held, CTRL reads 0x8 until a CTRL write clears it.
REQ-032 Timer 1 PRESET=3, CTRL=0xB (MODE1) -> HWInt[1] one-cycle pulse every 6 cycles.
REQ-033 Address 0x7F0C and 0x1000 with MemWriteM=1 -> DevHit=0, CPUReadData=0, no register change.
REQ-034 Assert reset mid-count (COUNT=3) -> next cycle COUNT=0, IDLE, HWInt=0.
REQ-035 Build without MIPS_BRIDGE_TIMER1_EN, write 0x7F14=7 -> reads 0, HWInt[1] stays 0.
